// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 34;
  localparam int DIV_CNT_W   = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift, trial-subtract, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    rem_o   = shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], 1'b0};
    // Remainder stays below the divisor, so bit WIDTH of diff is a true sign bit.
    if (!diff[WIDTH]) begin
      rem_o    = diff[WIDTH-1:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_divider.sv
// Iterative signed/unsigned restoring divider with busy/done handshake.
// Optional build macro DIV_EARLY_OUT_EN skips CALC for trivial divides.
module multicycle_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             issigned_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             divbyzero_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             signed_q, dvd_neg_q, dvs_neg_q, zero_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             busy_q, done_q, divbyzero_q;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             dvd_neg, dvs_neg, dvs_zero, early_out;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic             neg_quo;

  always_comb begin
    dvd_neg  = issigned_i & dividend_i[WIDTH-1];
    dvs_neg  = issigned_i & divisor_i[WIDTH-1];
    dvd_mag  = dvd_neg ? -dividend_i : dividend_i;
    dvs_mag  = dvs_neg ? -divisor_i : divisor_i;
    dvs_zero = (divisor_i == '0);
`ifdef DIV_EARLY_OUT_EN
    early_out = dvs_zero | (dvd_mag < dvs_mag);
`else
    early_out = 1'b0;
`endif
  end

  // Sign fixup; with a zero divisor the remainder comes back as the raw dividend.
  always_comb begin
    neg_quo = signed_q & (dvd_neg_q ^ dvs_neg_q) & ~zero_q;
    fix_quo = zero_q ? '1 : (neg_quo ? -quo_q : quo_q);
    fix_rem = (signed_q & dvd_neg_q) ? -rem_q : rem_q;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      signed_q    <= 1'b0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      divbyzero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (start_i) begin
              signed_q  <= issigned_i;
              dvd_neg_q <= dvd_neg;
              dvs_neg_q <= dvs_neg;
              zero_q    <= dvs_zero;
              dvs_q     <= dvs_mag;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              if (early_out) begin
                state_q <= FIXUP;
                rem_q   <= dvd_mag;
                quo_q   <= dvs_zero ? '1 : '0;
              end else begin
                state_q <= CALC;
                rem_q   <= '0;
                quo_q   <= dvd_mag;
              end
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          CALC: begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= FIXUP;
            end
          end
          FIXUP: begin
            quotient_q  <= fix_quo;
            remainder_q <= fix_rem;
            divbyzero_q <= zero_q;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign divbyzero_o = divbyzero_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Directed, table-driven bench for multicycle_divider plus control-path sequences.
module tb_multicycle_divider;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_ON = 1'b1;
`else
  localparam bit EARLY_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         issigned = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, divbyzero;

  multicycle_divider #(.WIDTH(W)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .issigned_i(issigned),
    .flush_i(flush),
    .dividend_i(dividend),
    .divisor_i(divisor),
    .quotient_o(quotient),
    .remainder_o(remainder),
    .busy_o(busy),
    .done_o(done),
    .divbyzero_o(divbyzero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge, then waits (bounded) for done.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output bit busy_ok);
    start    = 1'b1;
    issigned = sgn;
    dividend = a;
    divisor  = b;
    tick();
    start   = 1'b0;
    busy_ok = busy;
    lat     = -1;
    for (int i = 1; i <= DIV_LATENCY + 6; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic         sgn;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         early;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int  lat, exp_lat, n_done;
    bit  busy_ok, saw_done;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b1};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b1};
    vecs[5]  = '{1'b0, 32'd6,          32'd3,          32'd2,          32'd0,          1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 1'b1};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFD,  32'd10,         32'd0,          32'hFFFF_FFFD,  1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, 1'b0};
    vecs[13] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1'b1};

    #12;
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_divbyzero", W'(divbyzero), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Each vector after the first is issued in the done cycle of the previous one.
    for (int k = 0; k < 14; k++) begin
      run_div(vecs[k].sgn, vecs[k].dvd, vecs[k].dvs, lat, busy_ok);
      exp_lat = (EARLY_ON && vecs[k].early) ? 1 : DIV_LATENCY - 1;
      check($sformatf("vec%0d_quotient", k), quotient, vecs[k].q);
      check($sformatf("vec%0d_remainder", k), remainder, vecs[k].r);
      check($sformatf("vec%0d_divbyzero", k), W'(divbyzero), W'(vecs[k].dbz));
      check($sformatf("vec%0d_latency", k), W'(lat), W'(exp_lat));
      check($sformatf("vec%0d_busy", k), W'(busy_ok && !busy), W'(1));
    end

    tick();
    check("done_pulse_width", W'(done), '0);
    check("idle_busy", W'(busy), '0);

    // Flush mid-CALC: no done, previous (divide-by-zero) results held.
    start = 1'b1; issigned = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h10;
    tick();
    start = 1'b0;
    repeat (19) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", W'(busy), '0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", W'(saw_done), '0);
    check("flush_hold_quotient", quotient, 32'hFFFF_FFFF);
    check("flush_hold_remainder", remainder, 32'hFFFF_FFFB);
    check("flush_hold_divbyzero", W'(divbyzero), W'(1));

    // Flush and start together: flush wins.
    start = 1'b1; flush = 1'b1; dividend = 32'd6; divisor = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", W'(busy), '0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("flush_start_no_done", W'(saw_done), '0);

    // Second start during CALC must be ignored.
    start = 1'b1; issigned = 1'b0; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    lat = -1;
    n_done = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 10) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end
      tick();
      start = 1'b0;
      if (done) begin
        n_done++;
        if (lat < 0) lat = i;
      end
    end
    check("ignore_start_latency", W'(lat), W'(DIV_LATENCY - 1));
    check("ignore_start_done_count", W'(n_done), W'(1));
    check("ignore_start_quotient", quotient, 32'd14);
    check("ignore_start_remainder", remainder, 32'd2);

    // Asynchronous reset mid-CALC clears outputs immediately.
    start = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'h10;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_quotient", quotient, '0);
    check("mid_reset_remainder", remainder, '0);
    check("mid_reset_busy", W'(busy), '0);
    check("mid_reset_done", W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", W'(busy), '0);
    run_div(1'b0, 32'd6, 32'd3, lat, busy_ok);
    check("post_reset_quotient", quotient, 32'd2);
    check("post_reset_remainder", remainder, 32'd0);
    check("post_reset_latency", W'(lat), W'(DIV_LATENCY - 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
